// File: rtl/card_pkg.sv
// Shared card definitions: deck geometry, the card index type and the
// hand dealer state encoding used by the shuffler, dealer and display logic.
package card_pkg;

  localparam int NUM_CARDS = 7;
  localparam int CARD_W    = 6;
  localparam int DECK_SIZE = 52;
  localparam int RANK_W    = 4;
  localparam int SUIT_W    = 2;
  localparam int NUM_PAIRS = NUM_CARDS * (NUM_CARDS - 1) / 2;
  localparam int IDX_W     = 3;

  typedef logic [CARD_W-1:0] card_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DEAL  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } dealer_state_e;

  localparam idx_t  LAST_IDX   = idx_t'(NUM_CARDS - 1);
  localparam idx_t  LAST_I     = idx_t'(NUM_CARDS - 2);
  localparam card_t DECK_LIMIT = card_t'(DECK_SIZE);

  function automatic logic card_legal(input card_t c);
    return c < DECK_LIMIT;
  endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational card index -> rank/suit decode (suit = card/13, rank = card mod 13)
// built from a compare chain and one subtraction, no divider.
module card_decode
  import card_pkg::*;
(
  input  card_t             card_i,
  output logic [RANK_W-1:0] rank_o,
  output logic [SUIT_W-1:0] suit_o
);

  card_t base;
  card_t diff;
  logic  unused_hi;

  always_comb begin
    if (card_i >= card_t'(39)) begin
      suit_o = 2'd3;
      base   = card_t'(39);
    end else if (card_i >= card_t'(26)) begin
      suit_o = 2'd2;
      base   = card_t'(26);
    end else if (card_i >= card_t'(13)) begin
      suit_o = 2'd1;
      base   = card_t'(13);
    end else begin
      suit_o = 2'd0;
      base   = '0;
    end
  end

  // For legal cards the difference is always 0..12, so the top bits are zero.
  assign diff      = card_i - base;
  assign rank_o    = diff[RANK_W-1:0];
  assign unused_hi = ^diff[CARD_W-1:RANK_W];

endmodule

// File: rtl/hand_dealer.sv
// Snapshots a shuffled hand, validates it (range + pairwise duplicates) and
// streams the cards one per valid/ready handshake with rank/suit decode.
module hand_dealer
  import card_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  card_t             card0,
  input  card_t             card1,
  input  card_t             card2,
  input  card_t             card3,
  input  card_t             card4,
  input  card_t             card5,
  input  card_t             card6,
  input  logic              deal_req,
  output logic              out_valid,
  input  logic              out_ready,
  output card_t             out_card,
  output logic [RANK_W-1:0] out_rank,
  output logic [SUIT_W-1:0] out_suit,
  output idx_t              out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output dealer_state_e     dbg_state
);

  // Handshake: a card moves on every rising clk where out_valid && out_ready;
  // while out_valid is high and out_ready is low every out_* signal holds.

  dealer_state_e state_q;
  card_t         snap_q [NUM_CARDS];
  card_t         cards_in [NUM_CARDS];
  idx_t          idx_q;
  idx_t          pi_q;
  idx_t          pj_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          range_bad;
  logic          pair_eq;
  logic          pair_last;
  card_t         cur_card;

  always_comb begin
    cards_in[0] = card0;
    cards_in[1] = card1;
    cards_in[2] = card2;
    cards_in[3] = card3;
    cards_in[4] = card4;
    cards_in[5] = card5;
    cards_in[6] = card6;
  end

  always_comb begin
    range_bad = 1'b0;
    for (int k = 0; k < NUM_CARDS; k++) begin
      if (!card_legal(cards_in[k])) range_bad = 1'b1;
    end
  end

  assign pair_eq   = (snap_q[pi_q] == snap_q[pj_q]);
  assign pair_last = (pi_q == LAST_I) && (pj_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pi_q        <= '0;
      pj_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < NUM_CARDS; k++) snap_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (deal_req) begin
            for (int k = 0; k < NUM_CARDS; k++) snap_q[k] <= cards_in[k];
            pi_q  <= idx_t'(0);
            pj_q  <= idx_t'(1);
            idx_q <= '0;
            if (range_bad) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_CHECK;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        // One pair per cycle in the order (0,1)..(0,6),(1,2)..(5,6).
        S_CHECK: begin
          if (pair_eq) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (pair_last) begin
            state_q     <= S_DEAL;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
          end else if (pj_q == LAST_IDX) begin
            pi_q <= pi_q + idx_t'(1);
            pj_q <= pi_q + idx_t'(2);
          end else begin
            pj_q <= pj_q + idx_t'(1);
          end
        end
        S_DEAL: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              idx_q <= idx_q + idx_t'(1);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cur_card = out_valid_q ? snap_q[idx_q] : '0;

  card_decode u_decode (
    .card_i (cur_card),
    .rank_o (out_rank),
    .suit_o (out_suit)
  );

  assign out_valid = out_valid_q;
  assign out_card  = cur_card;
  assign out_idx   = out_valid_q ? idx_q : '0;
  assign out_last  = out_valid_q && (idx_q == LAST_IDX);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hand_dealer.sv
// Scoreboard bench for hand_dealer: directed hands with hand-computed rank/suit,
// a negedge monitor popping expected cards on every handshake.
module tb_hand_dealer;
  import card_pkg::*;

  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst;
  card_t             cards_tb [NUM_CARDS];
  logic              deal_req;
  logic              out_ready;
  logic              out_valid;
  card_t             out_card;
  logic [RANK_W-1:0] out_rank;
  logic [SUIT_W-1:0] out_suit;
  idx_t              out_idx;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;
  dealer_state_e     dbg_state;

  hand_dealer dut (
    .clk       (clk),
    .rst       (rst),
    .card0     (cards_tb[0]),
    .card1     (cards_tb[1]),
    .card2     (cards_tb[2]),
    .card3     (cards_tb[3]),
    .card4     (cards_tb[4]),
    .card5     (cards_tb[5]),
    .card6     (cards_tb[6]),
    .deal_req  (deal_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_card  (out_card),
    .out_rank  (out_rank),
    .out_suit  (out_suit),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_item_v;
  logic [W-1:0] hold_item;
  logic         held = 1'b0;
  wire  [W-1:0] cur_item = {out_idx, out_card, out_rank, out_suit, out_last};

  // Hands: 0=A, 1=duplicate, 2=B, 3=backpressure, 4=churn
  card_t       hand_c [5][7];
  logic [3:0]  hand_r [5][7];
  logic [1:0]  hand_s [5][7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [W-1:0] exp_item(input int h, input int k);
    return {idx_t'(k), hand_c[h][k], hand_r[h][k], hand_s[h][k], (k == NUM_CARDS - 1)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (out_valid && held) check("stall_hold", 32'(cur_item), 32'(hold_item));
      if (out_valid && out_ready) begin
        xfer_cnt++;
        held = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got item %h expected none", cur_item);
        end else begin
          exp_item_v = exp_q.pop_front();
          check("xfer_item", 32'(cur_item), 32'(exp_item_v));
        end
      end else if (out_valid) begin
        held      = 1'b1;
        hold_item = cur_item;
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cards(input int h);
    for (int k = 0; k < NUM_CARDS; k++) cards_tb[k] = hand_c[h][k];
  endtask

  task automatic push_hand(input int h);
    for (int k = 0; k < NUM_CARDS; k++) exp_q.push_back(exp_item(h, k));
  endtask

  task automatic capture_raw();
    deal_req = 1'b1;
    @(posedge clk);
    #1;
    deal_req = 1'b0;
  endtask

  task automatic capture(input int h);
    set_cards(h);
    capture_raw();
  endtask

  task automatic get_latency(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_done(output int done_at, output int pulses);
    int cyc;
    logic seen;
    cyc = 0;
    pulses = 0;
    done_at = 0;
    seen = 1'b0;
    while (cyc < 200 && !(seen && dbg_state == S_IDLE)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        pulses++;
        if (!seen) done_at = cyc;
        seen = 1'b1;
      end
    end
    if (!seen) check("done_timeout", 32'(cyc), 32'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_busy"},  32'(busy),      32'(0));
    check({tag, "_done"},  32'(done),      32'(0));
    check({tag, "_err"},   32'(err),       32'(0));
    check({tag, "_card"},  32'(out_card),  32'(0));
    check({tag, "_idx"},   32'(out_idx),   32'(0));
    check({tag, "_last"},  32'(out_last),  32'(0));
    check({tag, "_rank"},  32'(out_rank),  32'(0));
    check({tag, "_suit"},  32'(out_suit),  32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int p;
    int d;
    int base;
    int vcnt;
    int k;
    logic seen;
    logic pat [5];

    hand_c[0] = '{6'd5, 6'd17, 6'd30, 6'd51, 6'd0, 6'd12, 6'd44};
    hand_r[0] = '{4'd5, 4'd4, 4'd4, 4'd12, 4'd0, 4'd12, 4'd5};
    hand_s[0] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3};
    hand_c[1] = '{6'd3, 6'd9, 6'd22, 6'd9, 6'd40, 6'd1, 6'd7};
    hand_r[1] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    hand_s[1] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    hand_c[2] = '{6'd13, 6'd26, 6'd39, 6'd50, 6'd25, 6'd38, 6'd1};
    hand_r[2] = '{4'd0, 4'd0, 4'd0, 4'd11, 4'd12, 4'd12, 4'd1};
    hand_s[2] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0};
    hand_c[3] = '{6'd51, 6'd50, 6'd49, 6'd48, 6'd47, 6'd46, 6'd45};
    hand_r[3] = '{4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6};
    hand_s[3] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    hand_c[4] = '{6'd10, 6'd20, 6'd30, 6'd40, 6'd11, 6'd21, 6'd31};
    hand_r[4] = '{4'd10, 4'd7, 4'd4, 4'd1, 4'd11, 4'd8, 4'd5};
    hand_s[4] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    deal_req = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_CARDS; i++) cards_tb[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));

    // ---- capture and stream ----
    out_ready = 1'b1;
    push_hand(0);
    base = xfer_cnt;
    capture(0);
    check("a_busy", 32'(busy), 32'(1));
    check("a_state", 32'(dbg_state), 32'(S_CHECK));
    get_latency(n);
    check("a_latency", 32'(n), 32'(21));
    wait_done(d, p);
    check("a_done_at", 32'(d), 32'(7));
    check("a_done_pulses", 32'(p), 32'(1));
    check("a_xfers", 32'(xfer_cnt - base), 32'(7));
    check("a_q_empty", 32'(exp_q.size()), 32'(0));

    // ---- duplicate: pair (1,3) is the 8th compare, so ERR after 8 edges ----
    capture(1);
    repeat (7) @(posedge clk);
    #1;
    check("dup_err_before", 32'(err), 32'(0));
    check("dup_state_before", 32'(dbg_state), 32'(S_CHECK));
    @(posedge clk);
    #1;
    check("dup_err", 32'(err), 32'(1));
    check("dup_busy", 32'(busy), 32'(0));
    check("dup_state", 32'(dbg_state), 32'(S_ERR));
    vcnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) vcnt++;
    end
    check("dup_no_valid", 32'(vcnt), 32'(0));
    check("dup_err_held", 32'(err), 32'(1));

    push_hand(2);
    base = xfer_cnt;
    capture(2);
    check("b_err_cleared", 32'(err), 32'(0));
    check("b_state", 32'(dbg_state), 32'(S_CHECK));
    get_latency(n);
    check("b_latency", 32'(n), 32'(21));
    wait_done(d, p);
    check("b_done_pulses", 32'(p), 32'(1));
    check("b_xfers", 32'(xfer_cnt - base), 32'(7));

    // ---- range ----
    set_cards(0);
    cards_tb[4] = 6'd60;
    capture_raw();
    check("range_err", 32'(err), 32'(1));
    check("range_busy", 32'(busy), 32'(0));
    check("range_state", 32'(dbg_state), 32'(S_ERR));
    vcnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) vcnt++;
    end
    check("range_quiet", 32'(vcnt), 32'(0));

    // ---- backpressure ----
    push_hand(3);
    base = xfer_cnt;
    capture(3);
    check("bp_err_cleared", 32'(err), 32'(0));
    k = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      out_ready = pat[k % 5];
      @(posedge clk);
      #1;
      k++;
      if (done) seen = 1'b1;
    end
    check("bp_done_seen", 32'(seen), 32'(1));
    check("bp_xfers", 32'(xfer_cnt - base), 32'(7));
    check("bp_q_empty", 32'(exp_q.size()), 32'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // ---- input churn and ignored deal_req ----
    push_hand(4);
    base = xfer_cnt;
    capture(4);
    n = 0;
    while (!out_valid && n < 100) begin
      for (int i = 0; i < NUM_CARDS; i++) cards_tb[i] = card_t'($urandom_range(0, 63));
      deal_req = (dbg_state == S_CHECK || dbg_state == S_DEAL) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check("churn_latency", 32'(n), 32'(21));
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      for (int i = 0; i < NUM_CARDS; i++) cards_tb[i] = card_t'($urandom_range(0, 63));
      deal_req = (dbg_state == S_CHECK || dbg_state == S_DEAL) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      k++;
      if (done) seen = 1'b1;
    end
    deal_req = 1'b0;
    check("churn_done_seen", 32'(seen), 32'(1));
    @(posedge clk);
    #1;
    check("churn_idle", 32'(dbg_state), 32'(S_IDLE));
    check("churn_xfers", 32'(xfer_cnt - base), 32'(7));
    check("churn_q_empty", 32'(exp_q.size()), 32'(0));

    // ---- reset mid-DEAL after three transfers ----
    out_ready = 1'b1;
    push_hand(0);
    capture(0);
    get_latency(n);
    check("rst_latency", 32'(n), 32'(21));
    repeat (3) @(posedge clk);
    #1;
    check("rst_idx_before", 32'(out_idx), 32'(3));
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    check("midrst_remaining", 32'(exp_q.size()), 32'(4));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_hand(0);
    base = xfer_cnt;
    capture(0);
    get_latency(n);
    check("redeal_latency", 32'(n), 32'(21));
    check("redeal_idx0", 32'(out_idx), 32'(0));
    wait_done(d, p);
    check("redeal_done_pulses", 32'(p), 32'(1));
    check("redeal_xfers", 32'(xfer_cnt - base), 32'(7));
    check("redeal_q_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
